// File: rtl/vga_pkg.sv
// Default 640x480@60 raster constants, derived totals and the colour-bar table
// shared by the VGA timing generator.
package vga_pkg;

   localparam int unsigned DEF_H_VISIBLE = 640;
   localparam int unsigned DEF_H_FRONT   = 16;
   localparam int unsigned DEF_H_SYNC    = 96;
   localparam int unsigned DEF_H_BACK    = 48;
   localparam int unsigned DEF_V_VISIBLE = 480;
   localparam int unsigned DEF_V_FRONT   = 10;
   localparam int unsigned DEF_V_SYNC    = 2;
   localparam int unsigned DEF_V_BACK    = 33;

   function automatic int unsigned line_total(input int unsigned vis, input int unsigned front,
                                              input int unsigned sync, input int unsigned back);
      return vis + front + sync + back;
   endfunction

   localparam int unsigned DEF_H_TOTAL =
      line_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
   localparam int unsigned DEF_V_TOTAL =
      line_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

   localparam int unsigned NUM_BARS = 8;

   // Left to right: white, yellow, cyan, green, magenta, red, blue, black.
   localparam logic [23:0] BAR_COLOURS [NUM_BARS] = '{
      24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
   };

   function automatic logic [2:0] bar_index(input logic [9:0] x, input int unsigned bar_w);
      int unsigned q;
      q = 32'(x) / bar_w;
      return 3'(q);
   endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster generator: counters plus one registered output stage, pixel fetch one cycle ahead.
// Define VGA_TIMING_TEST_PATTERN_EN to drive colour bars instead of in_* data.
module vga_timing
   import vga_pkg::*;
#(
   parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
   parameter int unsigned H_FRONT    = DEF_H_FRONT,
   parameter int unsigned H_SYNC     = DEF_H_SYNC,
   parameter int unsigned H_BACK     = DEF_H_BACK,
   parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
   parameter int unsigned V_FRONT    = DEF_V_FRONT,
   parameter int unsigned V_SYNC     = DEF_V_SYNC,
   parameter int unsigned V_BACK     = DEF_V_BACK,
   parameter bit          H_SYNC_POL = 1'b0,
   parameter bit          V_SYNC_POL = 1'b0
) (
   input  logic       clk_pixel,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [7:0] in_red,
   input  logic [7:0] in_green,
   input  logic [7:0] in_blue,
   output logic       fetch,
   output logic [9:0] out_x,
   output logic [9:0] out_y,
   output logic [7:0] out_red,
   output logic [7:0] out_green,
   output logic [7:0] out_blue,
   output logic       out_hsync,
   output logic       out_vsync,
   output logic       out_blank,
   output logic       out_line_start,
   output logic       out_frame_start
);

   localparam int unsigned H_TOTAL = line_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
   localparam int unsigned V_TOTAL = line_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
   localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [9:0]  r_hcnt;
   logic [9:0]  r_vcnt;
   logic [9:0]  r_x;
   logic [9:0]  r_y;
   logic [23:0] r_rgb;
   logic        r_hsync;
   logic        r_vsync;
   logic        r_blank;
   logic        r_line_start;
   logic        r_frame_start;

   logic        w_vis;
   logic        w_hs_act;
   logic        w_vs_act;
   logic [23:0] w_rgb;

   assign w_vis    = (r_hcnt < H_VIS) && (r_vcnt < V_VIS);
   assign w_hs_act = (r_hcnt >= HS_BEG) && (r_hcnt < HS_END);
   assign w_vs_act = (r_vcnt >= VS_BEG) && (r_vcnt < VS_END);

   // The counters name the pixel that the next enabled edge presents, so it is requested now.
   assign fetch = enable & rst_n & w_vis;

`ifdef VGA_TIMING_TEST_PATTERN_EN
   assign w_rgb = w_vis ? BAR_COLOURS[bar_index(r_hcnt, H_VISIBLE / NUM_BARS)] : 24'h0;
`else
   assign w_rgb = w_vis ? {in_red, in_green, in_blue} : 24'h0;
`endif

   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         r_hcnt <= '0;
         r_vcnt <= '0;
      end else if (enable) begin
         if (r_hcnt == H_LAST) begin
            r_hcnt <= '0;
            r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 10'd1;
         end else begin
            r_hcnt <= r_hcnt + 10'd1;
         end
      end
   end

   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         r_x           <= '0;
         r_y           <= '0;
         r_rgb         <= '0;
         r_hsync       <= ~H_SYNC_POL;
         r_vsync       <= ~V_SYNC_POL;
         r_blank       <= 1'b1;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else if (enable) begin
         r_x           <= r_hcnt;
         r_y           <= r_vcnt;
         r_rgb         <= w_rgb;
         r_hsync       <= w_hs_act ? H_SYNC_POL : ~H_SYNC_POL;
         r_vsync       <= w_vs_act ? V_SYNC_POL : ~V_SYNC_POL;
         r_blank       <= ~w_vis;
         r_line_start  <= (r_hcnt == '0);
         r_frame_start <= (r_hcnt == '0) && (r_vcnt == '0);
      end else begin
         // Stalled: everything holds except the pulses, which must not repeat.
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end
   end

   assign out_x           = r_x;
   assign out_y           = r_y;
   assign out_red         = r_rgb[23:16];
   assign out_green       = r_rgb[15:8];
   assign out_blue        = r_rgb[7:0];
   assign out_hsync       = r_hsync;
   assign out_vsync       = r_vsync;
   assign out_blank       = r_blank;
   assign out_line_start  = r_line_start;
   assign out_frame_start = r_frame_start;

endmodule
